// File: rtl/fib_request_arbiter.sv
// Purpose : round-robin arbiter sharing one Fibonacci generator between NUM_REQ requesters.
// Latency : req sampled -> ack/gen_go next cycle; gen_done sampled -> rsp_valid next cycle.
// Backpressure: one computation in flight; losers hold req high in IDLE until acked.
// Optional feature: define FIB_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
module fib_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     gen_go,
    output logic [IDX_W-1:0]         gen_count_to,
    input  logic                     gen_done,
    input  logic [DATA_W-1:0]        gen_result
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   next_ptr;
    logic               win_found;
    logic               timeout_hit;
    int                 slot;

    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // First requesting slot at or after rr_ptr, wrapping around the requester set.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        slot      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && req[slot]) begin
                winner    = PTR_W'(slot);
                win_found = 1'b1;
            end
        end
    end

    // Pointer moves just past the requester that was served, so it has lowest priority next.
    always_comb begin
        next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end

`ifdef FIB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count WAIT cycles; cleared as the FSM leaves ISSUE so each wait starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The edge that takes the count to TIMEOUT is the abort edge.
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Arbitration FSM with all client- and generator-facing outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            ack          <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            gen_go       <= 1'b0;
            gen_count_to <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // gen_done seen here is stale and deliberately ignored.
                    if (win_found) begin
                        owner        <= winner;
                        gen_count_to <= req_idx[winner*IDX_W +: IDX_W];
                        ack          <= ONE_HOT_LSB << winner;
                        gen_go       <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ack    <= '0;
                    gen_go <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A real result beats a timeout landing on the same edge.
                    if (gen_done) begin
                        rsp_data  <= gen_result;
                        rsp_valid <= ONE_HOT_LSB << owner;
                        rsp_err   <= 1'b0;
                        state     <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_data  <= '0;
                        rsp_valid <= ONE_HOT_LSB << owner;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    rr_ptr    <= next_ptr;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
